// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the arbitrated adder.
package adder_arb_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REQ    = 4;

  typedef enum logic {EMPTY, FULL} buf_state_t;

  // Round-robin successor of grant g among n requesters.
  function automatic int unsigned next_ptr(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/adder.sv
// Parameterized ripple adder: {c_out, sum} = a + b + c_in.
module adder #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  c_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, c_in};
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr and wraps; ptr moves past the winner on advance.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);
  logic [ID_W-1:0] ptr;
  logic            found;

  // Two passes: indices at/after ptr first, then the wrapped-around ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (enable) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (ID_W'(i) >= ptr)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (ID_W'(i) < ptr)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (advance) ptr <= ID_W'(next_ptr(32'(grant_idx), NUM_REQ));
  end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NUM_REQ valid/ready requesters; single-entry registered result buffer.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_c_in,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic                          rsp_c_out
);
  buf_state_t state, state_nxt;
  logic                                 can_accept, accept;
  logic [NUM_REQ-1:0]                   grant;
  logic [ID_W-1:0]                      grant_idx;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   a_arr, b_arr;
  logic [DATA_WIDTH-1:0]                sum;
  logic                                 c_out;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // A full buffer can still take a new result when it is drained this same cycle.
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign req_ready  = grant;
  assign accept     = |(req_valid & grant);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .enable    (can_accept & rst_n),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .a     (a_arr[grant_idx]),
    .b     (b_arr[grant_idx]),
    .c_in  (req_c_in[grant_idx]),
    .sum   (sum),
    .c_out (c_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_c_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_id    <= grant_idx;
        rsp_sum   <= sum;
        rsp_c_out <= c_out;
      end
    end
  end

  assign rsp_valid = (state == FULL);
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table plus multi-cycle sequences.
module tb_adder_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;

  logic             clk, rst_n;
  logic [NR-1:0]    req_valid, req_ready, req_c_in;
  logic [NR*DW-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready, rsp_c_out;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_sum;

  adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c_in(req_c_in), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t        vecs[8];
  int          n_cmp = 0, n_err = 0;
  logic [15:0] ta[NR], tb[NR];
  logic        tc[NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = ta[i];
      req_b[i*DW +: DW] = tb[i];
      req_c_in[i]       = tc[i];
    end
  endtask

  function automatic logic [16:0] ref_add(input int i);
    return {1'b0, ta[i]} + {1'b0, tb[i]} + {16'd0, tc[i]};
  endfunction

  logic [16:0] e;
  logic [3:0]  exp_rdy;

  initial begin
    vecs[0] = '{2, 16'd10,   16'd10,   1'b0, 16'd20,   1'b0};
    vecs[1] = '{0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
    vecs[2] = '{1, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0};
    vecs[3] = '{3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{2, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[6] = '{0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[7] = '{3, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c_in = '0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_rsp_sum",   32'(rsp_sum),   32'h0);
    check("rst_rsp_c_out", 32'(rsp_c_out), 32'h0);
    @(negedge clk); rst_n = 1'b1; req_valid = '0;
    step();

    // Single-requester vectors; each ends with the result drained.
    for (int i = 0; i < 8; i++) begin
      req_a = '0; req_b = '0; req_c_in = '0;
      req_a[vecs[i].r*DW +: DW] = vecs[i].a;
      req_b[vecs[i].r*DW +: DW] = vecs[i].b;
      req_c_in[vecs[i].r]       = vecs[i].cin;
      req_valid = 4'(1 << vecs[i].r);
      rsp_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(1 << vecs[i].r));
      step();
      req_valid = '0;
      @(negedge clk);
      check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
      check($sformatf("v%0d_rsp_id", i),    32'(rsp_id),    32'(vecs[i].r));
      check($sformatf("v%0d_rsp_sum", i),   32'(rsp_sum),   32'(vecs[i].sum));
      check($sformatf("v%0d_rsp_c_out", i), 32'(rsp_c_out), 32'(vecs[i].cout));
      step();
    end

    // Round-robin: ptr is 0 after the last vector (requester 3).
    for (int i = 0; i < NR; i++) begin
      ta[i] = 16'h1111 * 16'(i + 1);
      tb[i] = 16'hF0F0;
      tc[i] = 1'(i);
    end
    load_ops();
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(1 << (k % NR)));
      if (k > 0) begin
        e = ref_add((k - 1) % NR);
        check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
        check($sformatf("rr%0d_rsp_id", k),    32'(rsp_id),    32'((k - 1) % NR));
        check($sformatf("rr%0d_rsp_sum", k),   32'(rsp_sum),   32'(e[15:0]));
        check($sformatf("rr%0d_rsp_c_out", k), 32'(rsp_c_out), 32'(e[16]));
      end
      step();
    end

    // Backpressure: buffer holds requester 1's result, ptr = 2.
    rsp_ready = 1'b0;
    e = ref_add(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'h0);
      check($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
      check($sformatf("bp%0d_rsp_id", k),    32'(rsp_id),    32'h1);
      check($sformatf("bp%0d_rsp_sum", k),   32'(rsp_sum),   32'(e[15:0]));
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req_ready", 32'(req_ready), 32'h4);
    step();
    e = ref_add(2);
    @(negedge clk);
    check("bp_b2b_rsp_valid", 32'(rsp_valid), 32'h1);
    check("bp_b2b_rsp_id",    32'(rsp_id),    32'h2);
    check("bp_b2b_rsp_sum",   32'(rsp_sum),   32'(e[15:0]));

    // Pointer wrap with gap: grant 1 alone to put ptr at 2, then {3,1}.
    req_valid = 4'b0010;
    @(negedge clk);
    check("gap_pre_req_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      @(negedge clk);
      check($sformatf("gap%0d_req_ready", k), 32'(req_ready), 32'(exp_rdy));
      step();
    end
    @(negedge clk);
    check("gap_last_rsp_id", 32'(rsp_id), 32'h1);

    // Reset mid-burst with a buffered result.
    req_valid = 4'hF;
    step();
    @(negedge clk);
    check("mrst_pre_rsp_valid", 32'(rsp_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mrst_rsp_id",    32'(rsp_id),    32'h0);
    check("mrst_rsp_sum",   32'(rsp_sum),   32'h0);
    check("mrst_rsp_c_out", 32'(rsp_c_out), 32'h0);
    check("mrst_req_ready", 32'(req_ready), 32'h0);
    step();
    check("mrst_hold_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;
    #1;
    check("mrst_first_grant", 32'(req_ready), 32'h1);
    step();
    e = ref_add(0);
    @(negedge clk);
    check("mrst_post_rsp_id",  32'(rsp_id),  32'h0);
    check("mrst_post_rsp_sum", 32'(rsp_sum), 32'(e[15:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
